// File: rtl/rob_pkg.sv
// Shared definitions for the N-way reorder buffer: entry layout helpers and
// the lowest-index priority select used to pick among matching channels.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif
`ifndef FIFO_SIZE
`define FIFO_SIZE 4
`endif

package rob_pkg;

  localparam int DEF_DATA_WIDTH = `AXI_DATA_WIDTH;
  localparam int DEF_ID_WIDTH   = `AXI_ID_WIDTH;
  localparam int DEF_TID_WIDTH  = `TID_WIDTH;
  localparam int DEF_FIFO_DEPTH = `FIFO_SIZE;

  // Widest entry / channel count the helpers handle; callers cast to their real widths.
  localparam int ENTRY_MAX = 256;
  localparam int SRC_MAX   = 8;

  function automatic int entry_width(input int tid_w, input int id_w, input int data_w);
    return tid_w + id_w + data_w;
  endfunction

  function automatic logic [ENTRY_MAX-1:0] field_mask(input int w);
    return (ENTRY_MAX'(1) << w) - ENTRY_MAX'(1);
  endfunction

  function automatic logic [ENTRY_MAX-1:0] entry_tid(input logic [ENTRY_MAX-1:0] e,
                                                     input int tid_w, input int id_w,
                                                     input int data_w);
    return (e >> (id_w + data_w)) & field_mask(tid_w);
  endfunction

  function automatic logic [ENTRY_MAX-1:0] entry_id(input logic [ENTRY_MAX-1:0] e,
                                                    input int id_w, input int data_w);
    return (e >> data_w) & field_mask(id_w);
  endfunction

  function automatic logic [ENTRY_MAX-1:0] entry_data(input logic [ENTRY_MAX-1:0] e,
                                                      input int data_w);
    return e & field_mask(data_w);
  endfunction

  function automatic logic [SRC_MAX-1:0] lowest_onehot(input logic [SRC_MAX-1:0] v);
    return v & (~v + SRC_MAX'(1));
  endfunction

  function automatic logic multi_hot(input logic [SRC_MAX-1:0] v);
    return (v & (v - SRC_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/rob_nway_if.sv
// Producer push ports, ordered read-response channel and status flags of the
// reorder buffer. master = the ROB itself, slave = the surrounding system.
interface rob_nway_if
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int TID_WIDTH   = DEF_TID_WIDTH,
  parameter int NUM_SRC     = 2,
  parameter int ENTRY_WIDTH = entry_width(TID_WIDTH, ID_WIDTH, DATA_WIDTH)
);

  logic                           valid_o;
  logic                           ready_i;
  logic [ID_WIDTH-1:0]            rid_o;
  logic [DATA_WIDTH-1:0]          rdata_o;
  logic [NUM_SRC-1:0]             full_o;
  logic [NUM_SRC-1:0]             write_en_i;
  logic [NUM_SRC*ENTRY_WIDTH-1:0] wdata_i;
  logic [TID_WIDTH-1:0]           expected_tid_o;
  logic                           err_dup_o;
  logic                           err_ovf_o;
  logic                           err_stall_o;
  logic                           err_clr_i;

  modport master (
    output valid_o, rid_o, rdata_o, full_o, expected_tid_o,
           err_dup_o, err_ovf_o, err_stall_o,
    input  ready_i, write_en_i, wdata_i, err_clr_i
  );

  modport slave (
    input  valid_o, rid_o, rdata_o, full_o, expected_tid_o,
           err_dup_o, err_ovf_o, err_stall_o,
    output ready_i, write_en_i, wdata_i, err_clr_i
  );

endinterface

// File: rtl/rob_fifo.sv
// First-word-fall-through channel FIFO; pointers carry one extra wrap bit so
// full and empty are distinguished without a counter. DEPTH must be a power of 2.
module rob_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rob_nway.sv
// N-channel reorder buffer: per-producer FWFT FIFOs whose heads are matched
// against the next expected tag and drained in tag order onto one valid/ready channel.
module rob_nway
  import rob_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int TID_WIDTH   = DEF_TID_WIDTH,
  parameter int NUM_SRC     = 2,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TID_START   = 1,
  parameter int ENTRY_WIDTH = entry_width(TID_WIDTH, ID_WIDTH, DATA_WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  rob_nway_if.master   bus
);

  logic [ENTRY_WIDTH-1:0] head     [NUM_SRC];
  logic [TID_WIDTH-1:0]   head_tid [NUM_SRC];
  logic [NUM_SRC-1:0]     empty;
  logic [NUM_SRC-1:0]     full;
  logic [NUM_SRC-1:0]     match;
  logic [NUM_SRC-1:0]     sel;
  logic [NUM_SRC-1:0]     pop;
  logic [NUM_SRC-1:0]     ovf_evt;

  logic                   load;
  logic                   dup_evt;
  logic                   stall_evt;
  logic [ENTRY_WIDTH-1:0] sel_entry;
  logic [ID_WIDTH-1:0]    sel_id;
  logic [DATA_WIDTH-1:0]  sel_data;

  logic                   valid_p1;
  logic [ID_WIDTH-1:0]    rid_p1;
  logic [DATA_WIDTH-1:0]  rdata_p1;
  logic [TID_WIDTH-1:0]   exp_tid_p1;
  logic                   err_dup_q;
  logic                   err_ovf_q;
  logic                   err_stall_q;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    rob_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.write_en_i[k]),
      .pop   (pop[k]),
      .din   (bus.wdata_i[k*ENTRY_WIDTH +: ENTRY_WIDTH]),
      .dout  (head[k]),
      .empty (empty[k]),
      .full  (full[k])
    );

    assign head_tid[k] = TID_WIDTH'(entry_tid(ENTRY_MAX'(head[k]), TID_WIDTH, ID_WIDTH, DATA_WIDTH));
    assign match[k]    = !empty[k] && (head_tid[k] == exp_tid_p1);
    assign pop[k]      = load && sel[k];
    assign ovf_evt[k]  = bus.write_en_i[k] && full[k] && !pop[k];
  end

  // Lowest-index matching channel wins; duplicates stay queued and raise err_dup.
  assign sel       = NUM_SRC'(lowest_onehot(SRC_MAX'(match)));
  assign load      = (|match) && (!valid_p1 || bus.ready_i);
  assign dup_evt   = multi_hot(SRC_MAX'(match));
  assign stall_evt = (&full) && !(|match);

  always_comb begin
    sel_entry = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel[k]) sel_entry = head[k];
    end
  end

  assign sel_id   = ID_WIDTH'(entry_id(ENTRY_MAX'(sel_entry), ID_WIDTH, DATA_WIDTH));
  assign sel_data = DATA_WIDTH'(entry_data(ENTRY_MAX'(sel_entry), DATA_WIDTH));

  // ---- output register stage (p1): IDLE when valid_p1=0, HOLD when 1 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_p1   <= 1'b0;
      rid_p1     <= '0;
      rdata_p1   <= '0;
      exp_tid_p1 <= TID_WIDTH'(TID_START);
    end else if (load) begin
      valid_p1   <= 1'b1;
      rid_p1     <= sel_id;
      rdata_p1   <= sel_data;
      exp_tid_p1 <= exp_tid_p1 + TID_WIDTH'(1);
    end else if (valid_p1 && bus.ready_i) begin
      valid_p1   <= 1'b0;
    end
  end

  // Sticky flags: an event in the clear cycle keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_dup_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_stall_q <= 1'b0;
    end else begin
      err_dup_q   <= dup_evt     || (err_dup_q   && !bus.err_clr_i);
      err_ovf_q   <= (|ovf_evt)  || (err_ovf_q   && !bus.err_clr_i);
      err_stall_q <= stall_evt   || (err_stall_q && !bus.err_clr_i);
    end
  end

  assign bus.valid_o        = valid_p1;
  assign bus.rid_o          = rid_p1;
  assign bus.rdata_o        = rdata_p1;
  assign bus.expected_tid_o = exp_tid_p1;
  assign bus.full_o         = full;
  assign bus.err_dup_o      = err_dup_q;
  assign bus.err_ovf_o      = err_ovf_q;
  assign bus.err_stall_o    = err_stall_q;

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: tag-order model feeding a scoreboard queue, a wrap
// vector table, and hand sequences for reorder, backpressure, errors and reset.
module tb_rob_nway;
  import rob_pkg::*;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int TW = 3;
  localparam int NS = 2;
  localparam int FD = 2;
  localparam int TS = 1;
  localparam int EW = entry_width(TW, IW, DW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_nway_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .TID_WIDTH(TW), .NUM_SRC(NS),
                .ENTRY_WIDTH(EW)) bus ();

  rob_nway #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .TID_WIDTH(TW), .NUM_SRC(NS),
             .FIFO_DEPTH(FD), .TID_START(TS)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            ch;
    logic [TW-1:0] tid;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [TW-1:0] exp_tid;
  } vec_t;

  beat_t         exp_q[$];
  beat_t         pend   [1<<TW];
  logic          pend_v [1<<TW];
  logic [TW-1:0] model_exp;
  logic          model_on;
  int            tests = 0;
  int            fails = 0;
  vec_t          tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < (1<<TW); i++) pend_v[i] = 1'b0;
    model_exp = TW'(TS);
  endtask

  // Reference ordering: park each entry by tag, release the in-order run.
  task automatic model_add(input logic [TW-1:0] tid, input beat_t b);
    pend[tid]   = b;
    pend_v[tid] = 1'b1;
    while (pend_v[model_exp]) begin
      exp_q.push_back(pend[model_exp]);
      pend_v[model_exp] = 1'b0;
      model_exp = model_exp + TW'(1);
    end
  endtask

  task automatic push(input int ch, input logic [TW-1:0] tid, input logic [IW-1:0] id,
                      input logic [DW-1:0] data);
    bus.write_en_i[ch] = 1'b1;
    bus.wdata_i[ch*EW +: EW] = {tid, id, data};
    if (model_on) model_add(tid, {id, data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.write_en_i = '0;
    bus.err_clr_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.write_en_i = '0;
    bus.err_clr_i  = 1'b0;
    model_clear();
    model_on = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
  endtask

  // Consumer side: a beat transfers at the next edge when valid && ready now.
  always @(negedge clk) begin
    beat_t b;
    if (!rst && bus.valid_o && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat actual rid=%0h rdata=%0h required=no beat",
                 bus.rid_o, bus.rdata_o);
      end else begin
        b = exp_q.pop_front();
        check("beat_rid", 32'(bus.rid_o), 32'(b.id));
        check("beat_rdata", 32'(bus.rdata_o), 32'(b.data));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 3'd1, 4'd0, 16'hA000, 3'd1};
    tbl[1] = '{1, 3'd2, 4'd1, 16'hA001, 3'd2};
    tbl[2] = '{0, 3'd3, 4'd2, 16'hA002, 3'd3};
    tbl[3] = '{1, 3'd4, 4'd3, 16'hA003, 3'd4};
    tbl[4] = '{0, 3'd5, 4'd4, 16'hA004, 3'd5};
    tbl[5] = '{1, 3'd6, 4'd5, 16'hA005, 3'd6};
    tbl[6] = '{0, 3'd7, 4'd6, 16'hA006, 3'd7};
    tbl[7] = '{1, 3'd0, 4'd7, 16'hA007, 3'd0};
    tbl[8] = '{0, 3'd1, 4'd8, 16'hA008, 3'd1};

    rst = 1'b1;
    bus.ready_i    = 1'b1;
    bus.write_en_i = '0;
    bus.wdata_i    = '0;
    bus.err_clr_i  = 1'b0;
    do_reset();

    check("rst_valid", 32'(bus.valid_o), 0);
    check("rst_rid", 32'(bus.rid_o), 0);
    check("rst_rdata", 32'(bus.rdata_o), 0);
    check("rst_exp_tid", 32'(bus.expected_tid_o), TS);
    check("rst_full", 32'(bus.full_o), 0);
    check("rst_errs", {29'd0, bus.err_dup_o, bus.err_ovf_o, bus.err_stall_o}, 0);

    // In-order on one channel
    push(0, 3'd1, 4'h1, 16'h0101); step();
    check("inord_valid_t1", 32'(bus.valid_o), 0);
    push(0, 3'd2, 4'h2, 16'h0202); step();
    check("inord_valid_t2", 32'(bus.valid_o), 1);
    push(0, 3'd3, 4'h3, 16'h0303); step();
    check("inord_valid_t3", 32'(bus.valid_o), 1);
    step();
    check("inord_valid_t4", 32'(bus.valid_o), 1);
    check("inord_exp_tid", 32'(bus.expected_tid_o), 4);
    step();
    check("inord_valid_idle", 32'(bus.valid_o), 0);
    wait_drain("inord_drain");

    // Cross-channel reorder
    do_reset();
    push(1, 3'd2, 4'h9, 16'h2222); step();
    check("reord_none_0", 32'(bus.valid_o), 0);
    step();
    check("reord_none_1", 32'(bus.valid_o), 0);
    step();
    check("reord_none_2", 32'(bus.valid_o), 0);
    push(0, 3'd1, 4'h8, 16'h1111); step();
    check("reord_none_3", 32'(bus.valid_o), 0);
    step();
    check("reord_first_valid", 32'(bus.valid_o), 1);
    check("reord_first_rid", 32'(bus.rid_o), 4'h8);
    step();
    check("reord_second_valid", 32'(bus.valid_o), 1);
    check("reord_second_rid", 32'(bus.rid_o), 4'h9);
    step();
    check("reord_idle", 32'(bus.valid_o), 0);
    check("reord_exp_tid", 32'(bus.expected_tid_o), 3);
    wait_drain("reord_drain");

    // Backpressure: held beat stable, no pops, then no bubble
    do_reset();
    bus.ready_i = 1'b0;
    push(0, 3'd1, 4'hA, 16'hAAAA); step();
    push(0, 3'd2, 4'hB, 16'hBBBB); step();
    push(0, 3'd3, 4'hC, 16'hCCCC); step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.valid_o), 1);
      check("bp_rid", 32'(bus.rid_o), 4'hA);
      check("bp_rdata", 32'(bus.rdata_o), 16'hAAAA);
      check("bp_full", 32'(bus.full_o), 2'b01);
      check("bp_exp_tid", 32'(bus.expected_tid_o), 2);
      step();
    end
    bus.ready_i = 1'b1;
    step();
    check("bp_next_valid", 32'(bus.valid_o), 1);
    check("bp_next_rid", 32'(bus.rid_o), 4'hB);
    step();
    check("bp_last_rid", 32'(bus.rid_o), 4'hC);
    step();
    check("bp_idle", 32'(bus.valid_o), 0);
    check("bp_exp_tid_end", 32'(bus.expected_tid_o), 4);
    wait_drain("bp_drain");

    // Tag wrap across channels, table-driven
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(tbl[i].ch, tbl[i].tid, tbl[i].id, tbl[i].data);
      step();
      check("wrap_exp_tid", 32'(bus.expected_tid_o), 32'(tbl[i].exp_tid));
    end
    step();
    check("wrap_exp_tid_end", 32'(bus.expected_tid_o), 2);
    wait_drain("wrap_drain");

    // Duplicate tag on two heads
    do_reset();
    model_on = 1'b0;
    push(0, 3'd1, 4'h5, 16'h0505);
    push(1, 3'd1, 4'h6, 16'h0606);
    exp_q.push_back({4'h5, 16'h0505});
    step();
    check("dup_not_yet", 32'(bus.err_dup_o), 0);
    step();
    check("dup_flag", 32'(bus.err_dup_o), 1);
    check("dup_valid", 32'(bus.valid_o), 1);
    check("dup_rid", 32'(bus.rid_o), 4'h5);
    check("dup_exp_tid", 32'(bus.expected_tid_o), 2);
    step();
    check("dup_no_second", 32'(bus.valid_o), 0);
    check("dup_sticky", 32'(bus.err_dup_o), 1);
    push(1, 3'd4, 4'h7, 16'h0707); step();
    check("dup_ch1_kept", 32'(bus.full_o), 2'b10);
    bus.err_clr_i = 1'b1; step();
    check("clr_all", {29'd0, bus.err_dup_o, bus.err_ovf_o, bus.err_stall_o}, 0);
    wait_drain("dup_drain");

    // Stall, overflow, clear vs. persistent event
    do_reset();
    model_on = 1'b0;
    push(0, 3'd5, 4'h1, 16'h5001); push(1, 3'd5, 4'h2, 16'h5002); step();
    push(0, 3'd5, 4'h3, 16'h5003); push(1, 3'd5, 4'h4, 16'h5004); step();
    check("stall_full", 32'(bus.full_o), 2'b11);
    check("stall_not_yet", 32'(bus.err_stall_o), 0);
    step();
    check("stall_flag", 32'(bus.err_stall_o), 1);
    check("ovf_not_yet", 32'(bus.err_ovf_o), 0);
    push(0, 3'd5, 4'h5, 16'h5005); step();
    check("ovf_flag", 32'(bus.err_ovf_o), 1);
    check("ovf_full_kept", 32'(bus.full_o), 2'b11);
    bus.err_clr_i = 1'b1; step();
    check("clr_ovf", 32'(bus.err_ovf_o), 0);
    check("clr_stall_event_wins", 32'(bus.err_stall_o), 1);
    check("clr_dup", 32'(bus.err_dup_o), 0);
    check("stall_no_beat", 32'(bus.valid_o), 0);

    // Asynchronous reset while a beat is held
    do_reset();
    bus.ready_i = 1'b0;
    push(0, 3'd1, 4'hD, 16'hD001); step();
    push(0, 3'd2, 4'hE, 16'hE002); step();
    check("ar_pre_valid", 32'(bus.valid_o), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.valid_o), 0);
    check("ar_full", 32'(bus.full_o), 0);
    check("ar_exp_tid", 32'(bus.expected_tid_o), TS);
    check("ar_rid", 32'(bus.rid_o), 0);
    model_clear();
    model_on = 1'b1;
    #2;
    rst = 1'b0;
    step();
    bus.ready_i = 1'b1;
    push(0, 3'd1, 4'h3, 16'h3003); step();
    push(1, 3'd2, 4'h4, 16'h4004); step();
    step();
    check("ar_restart_exp_tid", 32'(bus.expected_tid_o), 3);
    step();
    check("ar_restart_idle", 32'(bus.valid_o), 0);
    wait_drain("ar_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
